// File: rtl/pipe_pkg.sv
// Shared encodings and the stage-record layout for the pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Shadow record of one in-flight instruction at the default register-address width.
    typedef struct packed {
        logic                  v;
        logic [REG_AW_DEF-1:0] rd;
        logic                  rw;
        logic                  mr;
    } stage_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {WIDTH{1'b1}})) begin
            q_reg <= q_reg + WIDTH'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage core: tracks EX/MEM/WB destinations in a
// shadow pipe, drives stall/flush/bubble controls, operand forward selects and perf counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 1,
    parameter int FWD_EN   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    input  logic              cnt_clr,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } ex_rec_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
    } dst_rec_t;

    ex_rec_t           ex_reg;
    dst_rec_t          mem_reg;
    dst_rec_t          wb_reg;
    logic [REG_AW-1:0] ex_rs1_reg;
    logic [REG_AW-1:0] ex_rs2_reg;

    logic hazard;
    logic branch;
    logic stall_inc;
    logic flush_inc;

    // A producer only counts if it really writes; with ZERO_REG, x0 is never a dependency.
    function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic v,
                                       input logic rw, input logic [REG_AW-1:0] rd);
        return v && rw && (a == rd) && ((ZERO_REG == 0) || (rd != '0));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input dst_rec_t mem, input dst_rec_t wb);
        if (reg_match(rs, mem.v, mem.rw, mem.rd))
            return FWD_MEM;
        else if (reg_match(rs, wb.v, wb.rw, wb.rd))
            return FWD_WB;
        return FWD_RF;
    endfunction

    logic hz_ex;
    assign hz_ex = (id_rs1_used && reg_match(id_rs1, ex_reg.v, ex_reg.rw, ex_reg.rd)) ||
                   (id_rs2_used && reg_match(id_rs2, ex_reg.v, ex_reg.rw, ex_reg.rd));

    generate
        if (FWD_EN != 0) begin : g_fwd
            // Only a load in EX cannot be bypassed in time.
            assign hazard = id_valid && ex_reg.mr && hz_ex;
            assign fwd_a  = fwd_sel(ex_rs1_reg, mem_reg, wb_reg);
            assign fwd_b  = fwd_sel(ex_rs2_reg, mem_reg, wb_reg);
        end else begin : g_stall_only
            logic hz_mem;
            assign hz_mem = (id_rs1_used && reg_match(id_rs1, mem_reg.v, mem_reg.rw, mem_reg.rd)) ||
                            (id_rs2_used && reg_match(id_rs2, mem_reg.v, mem_reg.rw, mem_reg.rd));
            assign hazard = id_valid && (hz_ex || hz_mem);
            assign fwd_a  = FWD_RF;
            assign fwd_b  = FWD_RF;
        end
    endgenerate

    assign branch = ex_branch_taken && ex_reg.v;

    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        load_use_stall = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        if (ext_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            stall_inc = 1'b1;
        end else if (branch) begin
            // A taken branch kills the ID instruction, so its hazard is moot.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
        end else if (hazard) begin
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            id_ex_bubble   = 1'b1;
            load_use_stall = 1'b1;
            stall_inc      = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_reg     <= '0;
            mem_reg    <= '0;
            wb_reg     <= '0;
            ex_rs1_reg <= '0;
            ex_rs2_reg <= '0;
        end else if (!ext_stall) begin
            ex_reg.v   <= id_valid && !id_ex_bubble;
            ex_reg.rd  <= id_rd;
            ex_reg.rw  <= id_regwrite;
            ex_reg.mr  <= id_memread;
            ex_rs1_reg <= id_rs1;
            ex_rs2_reg <= id_rs2;
            mem_reg.v  <= ex_reg.v;
            mem_reg.rd <= ex_reg.rd;
            mem_reg.rw <= ex_reg.rw;
            wb_reg     <= mem_reg;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .q     (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (cnt_clr),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scenario bench for pipe_hazard_unit: default, 2-bit-counter and stall-only instances share stimulus.
module tb_pipe_hazard_unit;

    typedef struct packed {
        logic       es;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic       clr;
    } stim_t;

    // Expected {pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_a, fwd_b, load_use_stall}.
    typedef struct packed {
        logic [8:0] val;
        logic [8:0] care;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       ext_stall, id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread;
    logic       ex_branch_taken, cnt_clr;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        pc_en_m, if_id_en_m, flush_m, bubble_m, lus_m;
    logic [1:0]  fa_m, fb_m;
    logic [15:0] sc_m, fc_m;
    logic        pc_en_c, if_id_en_c, flush_c, bubble_c, lus_c;
    logic [1:0]  fa_c, fb_c;
    logic [1:0]  sc_c, fc_c;
    logic        pc_en_n, if_id_en_n, flush_n, bubble_n, lus_n;
    logic [1:0]  fa_n, fb_n;
    logic [15:0] sc_n, fc_n;
    logic [8:0]  obs_m, obs_c, obs_n;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq[$];

    assign obs_m = {pc_en_m, if_id_en_m, flush_m, bubble_m, fa_m, fb_m, lus_m};
    assign obs_c = {pc_en_c, if_id_en_c, flush_c, bubble_c, fa_c, fb_c, lus_c};
    assign obs_n = {pc_en_n, if_id_en_n, flush_n, bubble_n, fa_n, fb_n, lus_n};

    always #5 clock = ~clock;

    pipe_hazard_unit u_dut (
        .clock(clock), .reset(reset), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .pc_en(pc_en_m), .if_id_en(if_id_en_m), .if_id_flush(flush_m), .id_ex_bubble(bubble_m),
        .fwd_a(fa_m), .fwd_b(fb_m), .load_use_stall(lus_m), .stall_cnt(sc_m), .flush_cnt(fc_m)
    );

    pipe_hazard_unit #(.CNT_W(2)) u_c2 (
        .clock(clock), .reset(reset), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .pc_en(pc_en_c), .if_id_en(if_id_en_c), .if_id_flush(flush_c), .id_ex_bubble(bubble_c),
        .fwd_a(fa_c), .fwd_b(fb_c), .load_use_stall(lus_c), .stall_cnt(sc_c), .flush_cnt(fc_c)
    );

    pipe_hazard_unit #(.FWD_EN(0)) u_nf (
        .clock(clock), .reset(reset), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .pc_en(pc_en_n), .if_id_en(if_id_en_n), .if_id_flush(flush_n), .id_ex_bubble(bubble_n),
        .fwd_a(fa_n), .fwd_b(fb_n), .load_use_stall(lus_n), .stall_cnt(sc_n), .flush_cnt(fc_n)
    );

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.u1 = 1'b1; s.u2 = 1'b1; s.rw = 1'b1;
        return s;
    endfunction

    function automatic stim_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rd = rd; s.rs1 = rs1; s.u1 = 1'b1; s.rw = 1'b1; s.mr = 1'b1;
        return s;
    endfunction

    function automatic exp_t mk_e(input logic pc, input logic ie, input logic fl, input logic bu,
                                  input logic [1:0] fa, input logic [1:0] fb, input logic lus,
                                  input logic fwd_care);
        exp_t e;
        e.val  = {pc, ie, fl, bu, fa, fb, lus};
        e.care = fwd_care ? 9'h1FF : 9'b1111_0000_1;
        return e;
    endfunction

    function automatic exp_t en_n();
        return mk_e(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    endfunction

    task automatic drive(input stim_t s);
        ext_stall       = s.es;
        id_valid        = s.v;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_rs1_used     = s.u1;
        id_rs2_used     = s.u2;
        id_rd           = s.rd;
        id_regwrite     = s.rw;
        id_memread      = s.mr;
        ex_branch_taken = s.br;
        cnt_clr         = s.clr;
    endtask

    // Empties the shadow pipe and zeroes every counter.
    task automatic flush_pipe();
        stim_t s;
        s = nop();
        s.clr = 1'b1;
        repeat (3) begin
            drive(s);
            @(posedge clock); #1;
        end
        drive(nop());
    endtask

    task automatic test_reset();
        drive(nop());
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (obs_m !== en_n().val) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs_m, en_n().val);
        end
        n_checks++;
        if (sc_m !== 16'd0 || fc_m !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", sc_m, fc_m);
        end
        n_checks++;
        if (obs_n !== en_n().val) begin
            n_fail++; $display("FAIL reset_outputs_nf: got %b want %b", obs_n, en_n().val);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_independent();
        stim_t st[$];
        exp_t  ev[$];
        exp_t  e;
        flush_pipe();
        st.push_back(alu(5'd1, 5'd10, 5'd11)); ev.push_back(en_n());
        st.push_back(alu(5'd2, 5'd12, 5'd13)); ev.push_back(en_n());
        st.push_back(alu(5'd3, 5'd14, 5'd15)); ev.push_back(en_n());
        repeat (3) begin st.push_back(nop()); ev.push_back(en_n()); end
        foreach (st[i]) begin
            drive(st[i]);
            sbq.push_back(ev[i]);
            @(negedge clock);
            e = sbq.pop_front();
            n_checks++;
            if ((obs_m & e.care) !== (e.val & e.care)) begin
                n_fail++; $display("FAIL independent[%0d]: got %b want %b", i, obs_m, e.val);
            end
            $display("independent cycle %0d obs=%b", i, obs_m);
            @(posedge clock); #1;
        end
        n_checks++;
        if (sc_m !== 16'd0 || fc_m !== 16'd0) begin
            n_fail++; $display("FAIL independent_cnt: got %0d/%0d want 0/0", sc_m, fc_m);
        end
    endtask

    task automatic test_forward();
        stim_t st[$];
        exp_t  ev[$];
        exp_t  e;
        flush_pipe();
        st.push_back(alu(5'd5, 5'd1, 5'd2));  ev.push_back(en_n());
        st.push_back(alu(5'd6, 5'd5, 5'd5));  ev.push_back(en_n());
        st.push_back(alu(5'd9, 5'd5, 5'd21)); ev.push_back(mk_e(1, 1, 0, 0, 2'b10, 2'b10, 0, 1));
        st.push_back(nop());                  ev.push_back(mk_e(1, 1, 0, 0, 2'b01, 2'b00, 0, 1));
        st.push_back(nop());                  ev.push_back(en_n());
        // EX/MEM must win when both later stages write the same register.
        st.push_back(alu(5'd4, 5'd1, 5'd2));  ev.push_back(en_n());
        st.push_back(alu(5'd4, 5'd1, 5'd2));  ev.push_back(en_n());
        st.push_back(alu(5'd11, 5'd4, 5'd4)); ev.push_back(en_n());
        st.push_back(nop());                  ev.push_back(mk_e(1, 1, 0, 0, 2'b10, 2'b10, 0, 1));
        foreach (st[i]) begin
            drive(st[i]);
            sbq.push_back(ev[i]);
            @(negedge clock);
            e = sbq.pop_front();
            n_checks++;
            if ((obs_m & e.care) !== (e.val & e.care)) begin
                n_fail++; $display("FAIL forward[%0d]: got %b want %b", i, obs_m, e.val);
            end
            $display("forward cycle %0d obs=%b", i, obs_m);
            @(posedge clock); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t  ev[$];
        exp_t  e;
        flush_pipe();
        st.push_back(ld(5'd7, 5'd1));         ev.push_back(en_n());
        st.push_back(alu(5'd8, 5'd7, 5'd1));  ev.push_back(mk_e(0, 0, 0, 1, 2'b00, 2'b00, 1, 1));
        st.push_back(alu(5'd8, 5'd7, 5'd1));  ev.push_back(mk_e(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        st.push_back(nop());                  ev.push_back(mk_e(1, 1, 0, 0, 2'b01, 2'b00, 0, 1));
        foreach (st[i]) begin
            drive(st[i]);
            sbq.push_back(ev[i]);
            @(negedge clock);
            e = sbq.pop_front();
            n_checks++;
            if ((obs_m & e.care) !== (e.val & e.care)) begin
                n_fail++; $display("FAIL load_use[%0d]: got %b want %b", i, obs_m, e.val);
            end
            $display("load_use cycle %0d obs=%b", i, obs_m);
            @(posedge clock); #1;
        end
        n_checks++;
        if (sc_m !== 16'd1) begin
            n_fail++; $display("FAIL load_use_cnt: got %0d want 1", sc_m);
        end
    endtask

    task automatic test_branch_over_hazard();
        stim_t st[$];
        exp_t  ev[$];
        exp_t  e;
        stim_t s;
        flush_pipe();
        st.push_back(ld(5'd7, 5'd1)); ev.push_back(en_n());
        s = alu(5'd8, 5'd7, 5'd1); s.br = 1'b1;
        st.push_back(s);              ev.push_back(mk_e(1, 1, 1, 1, 2'b00, 2'b00, 0, 1));
        st.push_back(nop());          ev.push_back(mk_e(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        st.push_back(nop());          ev.push_back(en_n());
        foreach (st[i]) begin
            drive(st[i]);
            sbq.push_back(ev[i]);
            @(negedge clock);
            e = sbq.pop_front();
            n_checks++;
            if ((obs_m & e.care) !== (e.val & e.care)) begin
                n_fail++; $display("FAIL branch_hazard[%0d]: got %b want %b", i, obs_m, e.val);
            end
            $display("branch_hazard cycle %0d obs=%b", i, obs_m);
            @(posedge clock); #1;
        end
        n_checks++;
        if (fc_m !== 16'd1 || sc_m !== 16'd0) begin
            n_fail++; $display("FAIL branch_hazard_cnt: flush %0d stall %0d want 1/0", fc_m, sc_m);
        end
    endtask

    task automatic test_ext_stall();
        stim_t st[$];
        exp_t  ev[$];
        exp_t  e;
        stim_t s;
        flush_pipe();
        st.push_back(alu(5'd3, 5'd1, 5'd2)); ev.push_back(en_n());
        s = alu(5'd4, 5'd10, 5'd11); s.br = 1'b1; s.es = 1'b1;
        repeat (4) begin st.push_back(s); ev.push_back(mk_e(0, 0, 0, 0, 2'b00, 2'b00, 0, 1)); end
        s.es = 1'b0;
        st.push_back(s);                     ev.push_back(mk_e(1, 1, 1, 1, 2'b00, 2'b00, 0, 1));
        st.push_back(nop());                 ev.push_back(en_n());
        foreach (st[i]) begin
            drive(st[i]);
            sbq.push_back(ev[i]);
            @(negedge clock);
            e = sbq.pop_front();
            n_checks++;
            if ((obs_m & e.care) !== (e.val & e.care)) begin
                n_fail++; $display("FAIL ext_stall[%0d]: got %b want %b", i, obs_m, e.val);
            end
            $display("ext_stall cycle %0d obs=%b", i, obs_m);
            @(posedge clock); #1;
        end
        n_checks++;
        if (sc_m !== 16'd4 || fc_m !== 16'd1) begin
            n_fail++; $display("FAIL ext_stall_cnt: stall %0d flush %0d want 4/1", sc_m, fc_m);
        end
    endtask

    task automatic test_zero_reg();
        stim_t st[$];
        exp_t  ev[$];
        exp_t  e;
        flush_pipe();
        st.push_back(ld(5'd0, 5'd1));        ev.push_back(en_n());
        st.push_back(alu(5'd13, 5'd0, 5'd0)); ev.push_back(en_n());
        st.push_back(nop());                  ev.push_back(en_n());
        st.push_back(nop());                  ev.push_back(en_n());
        foreach (st[i]) begin
            drive(st[i]);
            sbq.push_back(ev[i]);
            @(negedge clock);
            e = sbq.pop_front();
            n_checks++;
            if ((obs_m & e.care) !== (e.val & e.care)) begin
                n_fail++; $display("FAIL zero_reg[%0d]: got %b want %b", i, obs_m, e.val);
            end
            $display("zero_reg cycle %0d obs=%b", i, obs_m);
            @(posedge clock); #1;
        end
        n_checks++;
        if (sc_m !== 16'd0) begin
            n_fail++; $display("FAIL zero_reg_cnt: got %0d want 0", sc_m);
        end
    endtask

    task automatic test_saturate();
        exp_t  e;
        stim_t s;
        flush_pipe();
        s = nop(); s.es = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(s);
            sbq.push_back(mk_e(0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
            @(negedge clock);
            e = sbq.pop_front();
            n_checks++;
            if (obs_c !== e.val) begin
                n_fail++; $display("FAIL saturate_out[%0d]: got %b want %b", i, obs_c, e.val);
            end
            $display("saturate cycle %0d stall_cnt2=%0d", i, sc_c);
            @(posedge clock); #1;
        end
        n_checks++;
        if (sc_c !== 2'd3 || fc_c !== 2'd0) begin
            n_fail++; $display("FAIL saturate_cnt2: got %0d/%0d want 3/0", sc_c, fc_c);
        end
        n_checks++;
        if (sc_m !== 16'd5) begin
            n_fail++; $display("FAIL saturate_cnt16: got %0d want 5", sc_m);
        end
        s.clr = 1'b1;
        drive(s);
        @(posedge clock); #1;
        n_checks++;
        if (sc_c !== 2'd0 || sc_m !== 16'd0) begin
            n_fail++; $display("FAIL cnt_clr: got %0d/%0d want 0/0", sc_c, sc_m);
        end
        drive(nop());
    endtask

    task automatic test_no_forward();
        stim_t st[$];
        exp_t  ev[$];
        exp_t  e;
        flush_pipe();
        st.push_back(alu(5'd5, 5'd1, 5'd2)); ev.push_back(en_n());
        st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(mk_e(0, 0, 0, 1, 2'b00, 2'b00, 1, 1));
        st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(mk_e(0, 0, 0, 1, 2'b00, 2'b00, 1, 1));
        st.push_back(alu(5'd6, 5'd5, 5'd5)); ev.push_back(en_n());
        st.push_back(nop());                 ev.push_back(en_n());
        foreach (st[i]) begin
            drive(st[i]);
            sbq.push_back(ev[i]);
            @(negedge clock);
            e = sbq.pop_front();
            n_checks++;
            if (obs_n !== e.val) begin
                n_fail++; $display("FAIL no_forward[%0d]: got %b want %b", i, obs_n, e.val);
            end
            $display("no_forward cycle %0d obs=%b", i, obs_n);
            @(posedge clock); #1;
        end
        n_checks++;
        if (sc_n !== 16'd2 || fc_n !== 16'd0) begin
            n_fail++; $display("FAIL no_forward_cnt: got %0d/%0d want 2/0", sc_n, fc_n);
        end
    endtask

    task automatic test_reset_mid();
        flush_pipe();
        drive(ld(5'd7, 5'd1));
        @(posedge clock); #1;
        drive(alu(5'd8, 5'd7, 5'd1));
        @(negedge clock);
        n_checks++;
        if (lus_m !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_pre: load_use_stall %b want 1", lus_m);
        end
        @(posedge clock); #1;
        n_checks++;
        if (sc_m !== 16'd1) begin
            n_fail++; $display("FAIL reset_mid_cnt_pre: got %0d want 1", sc_m);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (obs_m !== en_n().val || obs_n !== en_n().val) begin
            n_fail++; $display("FAIL reset_mid_out: got %b/%b want %b", obs_m, obs_n, en_n().val);
        end
        n_checks++;
        if (sc_m !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_cnt: got %0d want 0", sc_m);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs_m !== en_n().val) begin
            n_fail++; $display("FAIL reset_mid_release: got %b want %b", obs_m, en_n().val);
        end
        $display("reset_mid done obs=%b", obs_m);
        @(posedge clock); #1;
        drive(nop());
    endtask

    initial begin
        reset = 1'b1;
        drive(nop());
        test_reset();
        test_independent();
        test_forward();
        test_load_use();
        test_branch_over_hazard();
        test_ext_stall();
        test_zero_reg();
        test_saturate();
        test_no_forward();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
